data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 147 ++++++++++++++
 tb/tb_data_mem_responder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Single-port word memory behind a valid/ready load/store request channel.
// Each request runs IDLE -> (WAIT) -> ACCESS -> RESP; byte/half/word lanes, misaligned and illegal sizes are flagged.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_iobytes,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  state_t state, nxt;

  logic                    h_write;
  logic [DEPTH_LOG2+1:0]   h_addr;
  logic [31:0]             h_wdata;
  logic [3:0]              h_iob;
  logic [3:0]              cnt;
  logic [31:0]             res_data;
  logic                    res_err;
  logic [31:0]             mem [DEPTH];

  logic                    accept;
  logic                    bad;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [1:0]              off;
  logic [3:0]              be;
  logic [31:0]             wsh;
  logic [31:0]             mask;
  logic [31:0]             ldata;
  logic                    unused_addr_hi;

  // Address bits above the array span are ignored, so addresses wrap.
  assign unused_addr_hi = ^req_addr[31:DEPTH_LOG2+2];

  assign accept = req_valid & req_ready;
  assign idx    = h_addr[DEPTH_LOG2+1:2];
  assign off    = h_addr[1:0];
  assign be     = h_iob << off;
  assign wsh    = h_wdata << {off, 3'b000};

  always_comb begin
    bad  = 1'b0;
    mask = 32'h0;
    case (h_iob)
      4'b0001: mask = 32'h0000_00ff;
      4'b0011: begin mask = 32'h0000_ffff; bad = off[0]; end
      4'b1111: begin mask = 32'hffff_ffff; bad = (off != 2'd0); end
      default: bad = 1'b1;
    endcase
  end

  assign ldata = (mem[idx] >> {off, 3'b000}) & mask;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (accept) nxt = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (cnt == 4'd0) nxt = S_ACCESS;
      S_ACCESS: nxt = S_RESP;
      S_RESP:   if (rsp_valid && rsp_ready) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (state == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_write <= 1'b0;
      h_addr  <= '0;
      h_wdata <= 32'h0;
      h_iob   <= 4'h0;
    end else if (accept) begin
      h_write <= req_write;
      h_addr  <= req_addr[DEPTH_LOG2+1:0];
      h_wdata <= req_wdata;
      h_iob   <= req_iobytes;
    end
  end

  // Loaded with WAIT_STATES-1 so WAIT spans exactly WAIT_STATES cycles.
  always_ff @(posedge clk) begin
    if (rst)                                  cnt <= 4'd0;
    else if (accept && (WAIT_STATES > 0))     cnt <= 4'(WAIT_STATES - 1);
    else if (state == S_WAIT && cnt != 4'd0)  cnt <= cnt - 4'd1;
  end

  // Array is never cleared; a reset at the ACCESS closing edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && state == S_ACCESS && h_write && !bad) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_data <= 32'h0;
      res_err  <= 1'b0;
    end else if (state == S_ACCESS) begin
      res_data <= (bad || h_write) ? 32'h0 : ldata;
      res_err  <= bad;
    end
  end

  // Response is presented from the second RESP cycle on and held until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (state == S_RESP && !rsp_valid) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= res_data;
      rsp_err   <= res_err;
    end else if (state != S_RESP || rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: three instances (WAIT_STATES 0, 3, 2) share a clock and are exercised one at a time.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst         [3];
  logic        req_valid   [3];
  logic        req_ready   [3];
  logic        req_write   [3];
  logic [31:0] req_addr    [3];
  logic [31:0] req_wdata   [3];
  logic [3:0]  req_iobytes [3];
  logic        rsp_valid   [3];
  logic        rsp_ready   [3];
  logic [31:0] rsp_rdata   [3];
  logic        rsp_err     [3];

  int tests = 0;
  int fails = 0;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      localparam int WS = (g == 0) ? 0 : ((g == 1) ? 3 : 2);
      data_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst[g]),
        .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_write(req_write[g]),
        .req_addr(req_addr[g]), .req_wdata(req_wdata[g]), .req_iobytes(req_iobytes[g]),
        .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
        .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full request/response; lat = edges from acceptance until rsp_valid is seen.
  task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] iob, output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = w; req_addr[d] = a;
    req_wdata[d] = wd;   req_iobytes[d] = iob;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_wdata[d] = 32'h5a5a5a5a; req_addr[d] = 32'hffff_ffff;
    lat = 0;
    while (!rsp_valid[d] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    @(negedge clk); rsp_ready[d] = 1'b1;
    @(posedge clk); #1; rsp_ready[d] = 1'b0;
    chk("ready_after_hs", req_ready[d], 1'b1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_addr[d] = 32'h0;
      req_wdata[d] = 32'h0; req_iobytes[d] = 4'h0; rsp_ready[d] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready[0], 1'b1);
    chk("rst_valid", rsp_valid[0], 1'b0);
    chk("rst_rdata", rsp_rdata[0], 32'h0);
    chk("rst_err",   rsp_err[0],   1'b0);
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // WAIT_STATES = 0: basic word store/load
    xact(0, 1'b1, 32'h10, 32'hdeadbeef, 4'b1111, rd, er, lat);
    chk("st_word_lat", lat, 2);
    chk("st_word_err", er, 1'b0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'b1111, rd, er, lat);
    chk("ld_word_lat", lat, 2);
    chk("ld_word_data", rd, 32'hdeadbeef);
    chk("ld_word_err", er, 1'b0);

    // Byte and half lanes
    xact(0, 1'b1, 32'h13, 32'hffff_ffaa, 4'b0001, rd, er, lat);
    chk("st_byte_err", er, 1'b0);
    xact(0, 1'b1, 32'h10, 32'hffff_1234, 4'b0011, rd, er, lat);
    chk("st_half_err", er, 1'b0);
    xact(0, 1'b0, 32'h10, 32'h0, 4'b1111, rd, er, lat);
    chk("ld_word_lanes", rd, 32'haaad1234);
    xact(0, 1'b0, 32'h12, 32'h0, 4'b0001, rd, er, lat);
    chk("ld_byte_12", rd, 32'h000000ad);
    xact(0, 1'b0, 32'h12, 32'h0, 4'b0011, rd, er, lat);
    chk("ld_half_12", rd, 32'h0000aaad);

    // Misaligned and illegal sizes
    xact(0, 1'b0, 32'h11, 32'h0, 4'b1111, rd, er, lat);
    chk("mis_word_err", er, 1'b1);
    chk("mis_word_data", rd, 32'h0);
    chk("mis_word_lat", lat, 2);
    xact(0, 1'b1, 32'h13, 32'h5555, 4'b0011, rd, er, lat);
    chk("mis_half_err", er, 1'b1);
    xact(0, 1'b0, 32'h10, 32'h0, 4'b1111, rd, er, lat);
    chk("mis_half_nowrite", rd, 32'haaad1234);
    xact(0, 1'b0, 32'h10, 32'h0, 4'b0111, rd, er, lat);
    chk("bad_iob_err", er, 1'b1);
    chk("bad_iob_data", rd, 32'h0);

    // Address wrap at 1 KiB
    xact(0, 1'b1, 32'h400, 32'h01020304, 4'b1111, rd, er, lat);
    xact(0, 1'b0, 32'h000, 32'h0, 4'b1111, rd, er, lat);
    chk("wrap_data", rd, 32'h01020304);

    // WAIT_STATES = 3 with response backpressure
    xact(1, 1'b1, 32'h0, 32'hcafef00d, 4'b1111, rd, er, lat);
    chk("ws3_st_lat", lat, 5);
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h0; req_iobytes[1] = 4'b1111;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    for (int m = 1; m <= 5; m++) begin
      @(posedge clk); #1;
      chk("ws3_valid_rise", rsp_valid[1], (m == 5));
    end
    for (int m = 0; m < 5; m++) begin
      @(posedge clk); #1;
      chk("ws3_hold_valid", rsp_valid[1], 1'b1);
      chk("ws3_hold_data", rsp_rdata[1], 32'hcafef00d);
      chk("ws3_hold_ready", req_ready[1], 1'b0);
    end
    @(negedge clk); rsp_ready[1] = 1'b1;
    @(posedge clk); #1; rsp_ready[1] = 1'b0;
    chk("ws3_ready_after", req_ready[1], 1'b1);
    chk("ws3_valid_after", rsp_valid[1], 1'b0);
    chk("ws3_rdata_after", rsp_rdata[1], 32'h0);

    // WAIT_STATES = 2: reset during WAIT aborts the store
    xact(2, 1'b1, 32'h20, 32'h11111111, 4'b1111, rd, er, lat);
    chk("ws2_st_lat", lat, 4);
    @(negedge clk);
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[2] = 32'h20;
    req_wdata[2] = 32'hffffffff; req_iobytes[2] = 4'b1111;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    @(negedge clk); rst[2] = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ready", req_ready[2], 1'b1);
    chk("midrst_valid", rsp_valid[2], 1'b0);
    @(negedge clk); rst[2] = 1'b0;
    for (int m = 0; m < 6; m++) begin
      @(posedge clk); #1;
      chk("midrst_no_rsp", rsp_valid[2], 1'b0);
    end
    xact(2, 1'b0, 32'h20, 32'h0, 4'b1111, rd, er, lat);
    chk("midrst_data", rd, 32'h11111111);
    chk("midrst_lat", lat, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
